// File: rtl/wave_disp_pkg.sv
// Shared types and lane geometry for the multi-channel waveform capture/display block.
package wave_disp_pkg;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_FILL  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef logic [11:0] rgb12_t;

  // Top row of the trace in a lane: louder samples sit higher on screen.
  function automatic int unsigned lane_ytop(input int unsigned lane,
                                            input int unsigned lane_h,
                                            input int unsigned smp,
                                            input int unsigned smp_w,
                                            input int unsigned shift);
    int unsigned full;
    full = (32'd1 << smp_w) - 32'd1;
    return lane * lane_h + ((full - smp) >> shift);
  endfunction

endpackage

// File: rtl/wave_capture_display_if.sv
// Sample stream from the mic sampler: one valid strobe plus all channels packed.
interface wave_capture_display_if #(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 10
);
  logic                       sample_en;
  logic [N_CH*SAMPLE_W-1:0]   sample_in;

  modport master (output sample_en, output sample_in);
  modport slave  (input  sample_en, input  sample_in);
endinterface

// File: rtl/wave_bank_ram.sv
// Two-bank sample store: synchronous write into the capture bank, asynchronous read of the display bank.
module wave_bank_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 20,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [2][DEPTH];

  // Sample memory is deliberately left unreset; the display is gated until a full frame exists.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_bank][wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank][rd_idx];

endmodule

// File: rtl/wave_capture_display.sv
// Multi-channel ping-pong waveform capture with decimation and level/auto trigger,
// rendered as per-channel lanes (line or filled bar) on the VGA pixel grid.
module wave_capture_display
  import wave_disp_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int SAMPLE_W     = 10,
  parameter int DEPTH        = 640,
  parameter int X_OFFSET     = 640,
  parameter int COORD_W      = 12,
  parameter int LANE_H       = 512,
  parameter int LANE_SHIFT   = 1,
  parameter int TRIG_TIMEOUT = 2047
) (
  input  logic                  clk_sample,
  input  logic                  rst_n,
  wave_capture_display_if.slave smp,
  input  logic                  freeze,
  input  logic                  trig_en,
  input  logic [SAMPLE_W-1:0]   trig_level,
  input  logic [3:0]            decim,
  input  logic                  bar_mode,
  input  logic [N_CH*12-1:0]    line_colour,
  input  logic [11:0]           bar_colour,
  input  logic [11:0]           bar_alt_colour,
  input  logic [COORD_W-1:0]    VGA_HORZ_COORD,
  input  logic [COORD_W-1:0]    VGA_VERT_COORD,
  output logic [3:0]            VGA_Red_waveform,
  output logic [3:0]            VGA_Green_waveform,
  output logic [3:0]            VGA_Blue_waveform,
  output logic                  frame_done,
  output logic                  capturing
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TO_W  = $clog2(TRIG_TIMEOUT + 1);
  localparam int W     = N_CH * SAMPLE_W;
  localparam int XW    = COORD_W + 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [3:0]          dec_cnt_q, dec_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [SAMPLE_W-1:0] prev_s0_q, prev_s0_d;
  logic                cap_bank_q, cap_bank_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                capturing_q, capturing_d;

  logic                acc, trig_hit, we;
  logic [IDX_W-1:0]    widx, rd_idx;
  logic [SAMPLE_W-1:0] s0;
  logic [W-1:0]        rd_data;

  assign s0       = smp.sample_in[SAMPLE_W-1:0];
  assign acc      = smp.sample_en && (dec_cnt_q == decim);
  assign trig_hit = !trig_en
                 || ((prev_s0_q < trig_level) && (s0 >= trig_level))
                 || (to_cnt_q == TO_W'(TRIG_TIMEOUT));

  // Decimation, trigger search and frame fill sequencing.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    dec_cnt_d     = dec_cnt_q;
    to_cnt_d      = to_cnt_q;
    prev_s0_d     = prev_s0_q;
    cap_bank_d    = cap_bank_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    we            = 1'b0;
    widx          = wr_idx_q;

    if (acc) begin
      dec_cnt_d = '0;
      prev_s0_d = s0;
    end else if (smp.sample_en) begin
      dec_cnt_d = dec_cnt_q + 4'd1;
    end

    case (state_q)
      ST_ARMED: begin
        if (!freeze && acc) begin
          if (trig_hit) begin
            we       = 1'b1;
            widx     = '0;
            wr_idx_d = IDX_W'(1);
            to_cnt_d = '0;
            state_d  = ST_FILL;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      ST_FILL: begin
        if (acc) begin
          we = 1'b1;
          if (wr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_DONE;
          else                               wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (!freeze) begin
          cap_bank_d    = ~cap_bank_q;
          frame_valid_d = 1'b1;
          frame_done_d  = 1'b1;
          wr_idx_d      = '0;
          state_d       = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase

    capturing_d = (state_d == ST_FILL);
  end

  // Control state register.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ARMED;
      wr_idx_q      <= '0;
      dec_cnt_q     <= '0;
      to_cnt_q      <= '0;
      prev_s0_q     <= '0;
      cap_bank_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      capturing_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      dec_cnt_q     <= dec_cnt_d;
      to_cnt_q      <= to_cnt_d;
      prev_s0_q     <= prev_s0_d;
      cap_bank_q    <= cap_bank_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      capturing_q   <= capturing_d;
    end
  end

  assign frame_done = frame_done_q;
  assign capturing  = capturing_q;

  // The display always reads the bank opposite the one being captured.
  wave_bank_ram #(.DEPTH(DEPTH), .WIDTH(W), .IDX_W(IDX_W)) u_ram (
    .clk     (clk_sample),
    .we      (we),
    .wr_bank (cap_bank_q),
    .wr_idx  (widx),
    .wr_data (smp.sample_in),
    .rd_bank (~cap_bank_q),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  logic [XW-1:0] xe, ye, col;
  logic          in_win, alt_col;
  rgb12_t        pix_rgb;

  assign xe      = {1'b0, VGA_HORZ_COORD};
  assign ye      = {1'b0, VGA_VERT_COORD};
  assign in_win  = (xe >= XW'(X_OFFSET)) && (xe <= XW'(X_OFFSET + DEPTH - 1));
  assign col     = xe - XW'(X_OFFSET);
  assign rd_idx  = in_win ? col[IDX_W-1:0] : '0;
  // Alternate bar shading follows the column inside the window, not the raw VGA x.
  assign alt_col = (col % XW'(3)) == '0;

  // Lane renderer: the trace row wins over bar fill; lanes never overlap.
  always_comb begin
    logic [SAMPLE_W-1:0] smp_c;
    logic [XW-1:0]       ytop, yhi;
    pix_rgb = '0;
    smp_c   = '0;
    ytop    = '0;
    yhi     = '0;
    if (frame_valid_q && in_win) begin
      for (int c = 0; c < N_CH; c++) begin
        smp_c = rd_data[c*SAMPLE_W +: SAMPLE_W];
        ytop  = XW'(lane_ytop(c, LANE_H, 32'(smp_c), SAMPLE_W, LANE_SHIFT));
        yhi   = XW'((c + 1) * LANE_H);
        if (ye == ytop)
          pix_rgb = line_colour[c*12 +: 12];
        else if (bar_mode && (ye > ytop) && (ye < yhi))
          pix_rgb = alt_col ? bar_alt_colour : bar_colour;
      end
    end
  end

  assign VGA_Red_waveform   = pix_rgb[11:8];
  assign VGA_Green_waveform = pix_rgb[7:4];
  assign VGA_Blue_waveform  = pix_rgb[3:0];

endmodule

// File: tb/tb_wave_capture_display.sv
// Scoreboard bench: stimulus queues expected frame_done timing and pixel/status values,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_wave_capture_display;

  localparam int N_CH  = 2;
  localparam int SW    = 10;
  localparam logic [11:0] LC0  = 12'hF00;
  localparam logic [11:0] LC1  = 12'h0F0;
  localparam logic [11:0] BARC = 12'h00F;
  localparam logic [11:0] ALTC = 12'h5A5;

  logic clk_sample = 1'b0;
  always #5 clk_sample = ~clk_sample;

  logic        rst_n, freeze, trig_en, bar_mode;
  logic [9:0]  trig_level;
  logic [3:0]  decim;
  logic [23:0] line_colour;
  logic [11:0] vx, vy;
  logic [3:0]  red, green, blue;
  logic        frame_done, capturing;

  assign line_colour = {LC1, LC0};

  wave_capture_display_if #(.N_CH(N_CH), .SAMPLE_W(SW)) smp_if ();

  wave_capture_display #(.TRIG_TIMEOUT(15)) dut (
    .clk_sample         (clk_sample),
    .rst_n              (rst_n),
    .smp                (smp_if),
    .freeze             (freeze),
    .trig_en            (trig_en),
    .trig_level         (trig_level),
    .decim              (decim),
    .bar_mode           (bar_mode),
    .line_colour        (line_colour),
    .bar_colour         (BARC),
    .bar_alt_colour     (ALTC),
    .VGA_HORZ_COORD     (vx),
    .VGA_VERT_COORD     (vy),
    .VGA_Red_waveform   (red),
    .VGA_Green_waveform (green),
    .VGA_Blue_waveform  (blue),
    .frame_done         (frame_done),
    .capturing          (capturing)
  );

  typedef struct { int cyc; int cap_len; } fd_exp_t;
  typedef struct { logic [13:0] exp; string name; } px_exp_t;

  fd_exp_t fd_q[$];
  px_exp_t px_q[$];

  int   cyc = 0;
  int   n_run = 0, n_fail = 0, cap_cnt = 0;
  logic px_chk = 1'b0, end_chk = 1'b0, end_done = 1'b0;

  always @(posedge clk_sample) cyc <= cyc + 1;

  // Monitor: compares frame_done timing, capture length and requested pixel/status samples.
  always @(negedge clk_sample) begin
    fd_exp_t     fe;
    px_exp_t     pe;
    logic [13:0] act;
    if (capturing === 1'b1) cap_cnt++;
    if (frame_done === 1'b1) begin
      n_run++;
      if (fd_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_done_unexpected: seen at cycle %0d, none expected", cyc);
      end else begin
        fe = fd_q.pop_front();
        if (cyc != fe.cyc) begin
          n_fail++;
          $display("FAIL frame_done_cycle: got %0d want %0d", cyc, fe.cyc);
        end
        n_run++;
        if (cap_cnt != fe.cap_len) begin
          n_fail++;
          $display("FAIL capturing_len: got %0d want %0d", cap_cnt, fe.cap_len);
        end
      end
      cap_cnt = 0;
    end
    if (px_chk) begin
      n_run++;
      act = {capturing, frame_done, red, green, blue};
      if (px_q.size() == 0) begin
        n_fail++;
        $display("FAIL pixel_queue_empty: got %h", act);
      end else begin
        pe = px_q.pop_front();
        if (act !== pe.exp) begin
          n_fail++;
          $display("FAIL %s: got {cap,fd,rgb}=%h want %h", pe.name, act, pe.exp);
        end
      end
    end
    if (end_chk && !end_done) begin
      n_run++;
      if (fd_q.size() != 0 || px_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_expectations: frame_done %0d pixel %0d want 0 0", fd_q.size(), px_q.size());
      end
      end_done = 1'b1;
    end
  end

  function automatic logic [13:0] rgbx(input logic [11:0] c);
    return {2'b00, c};
  endfunction

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic send(input int s0, input int s1);
    smp_if.sample_en = 1'b1;
    smp_if.sample_in = {SW'(s1), SW'(s0)};
    tick();
  endtask

  task automatic idle(input int n);
    smp_if.sample_en = 1'b0;
    repeat (n) tick();
  endtask

  // dcyc: cycles from now until the pulse is visible at a negedge.
  task automatic expect_fd(input int dcyc, input int cap_len);
    fd_exp_t e;
    e.cyc     = cyc + dcyc;
    e.cap_len = cap_len;
    fd_q.push_back(e);
  endtask

  task automatic pix(input int x, input int y, input logic [13:0] exp, input string name);
    px_exp_t e;
    smp_if.sample_en = 1'b0;
    vx = 12'(x);
    vy = 12'(y);
    e.exp  = exp;
    e.name = name;
    px_q.push_back(e);
    px_chk = 1'b1;
    tick();
    px_chk = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; freeze = 1'b0; trig_en = 1'b0; bar_mode = 1'b0;
    trig_level = '0; decim = '0; vx = '0; vy = '0;
    smp_if.sample_en = 1'b0; smp_if.sample_in = '0;
    tick(); tick();
    pix(640, 511, rgbx(12'h000), "reset_blank");
    rst_n = 1'b1;
    tick();

    // Test 1: free-run ramp, ch0=k, ch1=1023-k; trigger sample written from ARMED, 639 cycles in FILL.
    for (int k = 0; k < 640; k++) begin
      if (k == 639) expect_fd(2, 639);
      send(k, 1023 - k);
    end
    idle(4);
    pix(640, 511, rgbx(LC0), "t1_col0_ch0");
    pix(641, 511, rgbx(LC0), "t1_col1_ch0");
    pix(642, 511, rgbx(12'h000), "t1_col2_gap");
    pix(642, 510, rgbx(LC0), "t1_col2_ch0");
    pix(640, 512, rgbx(LC1), "t1_col0_ch1");
    pix(1279, 192, rgbx(LC0), "t1_col639_ch0");
    pix(1279, 831, rgbx(LC1), "t1_col639_ch1");
    pix(639, 511, rgbx(12'h000), "t1_left_of_window");
    pix(1280, 192, rgbx(12'h000), "t1_right_of_window");

    // Test 5: freeze raised mid-FILL; old frame stays on screen until freeze drops.
    for (int k = 0; k < 640; k++) begin
      if (k == 300) freeze = 1'b1;
      send(1023, 1023);
    end
    send(0, 0); send(0, 0); send(0, 0);
    idle(2);
    pix(640, 511, rgbx(LC0), "t5_frozen_old_shown");
    pix(640, 0, rgbx(12'h000), "t5_frozen_new_hidden");
    freeze = 1'b0;
    expect_fd(1, 639);
    idle(4);
    pix(640, 0, rgbx(LC0), "t5_new_col0_ch0");
    pix(640, 512, rgbx(LC1), "t5_new_col0_ch1");
    pix(640, 511, rgbx(12'h000), "t5_old_gone");
    pix(1279, 0, rgbx(LC0), "t5_done_samples_dropped");

    // Test 2: rising crossing of 600 on ch0.
    do_reset();
    trig_en = 1'b1; trig_level = 10'd600;
    send(100, 0); send(500, 0); send(599, 0);
    pix(640, 211, rgbx(12'h000), "t2_still_armed");
    send(600, 0);
    for (int k = 1; k < 640; k++) begin
      if (k == 639) expect_fd(2, 639);
      send(0, 0);
    end
    idle(4);
    pix(640, 211, rgbx(LC0), "t2_col0_is_600");
    pix(640, 210, rgbx(12'h000), "t2_col0_above");
    pix(641, 511, rgbx(LC0), "t2_col1_zero");

    // Test 3: constant ch0 never crosses; auto-trigger on the 16th accepted sample.
    do_reset();
    trig_en = 1'b1; trig_level = 10'd600;
    repeat (15) send(0, 0);
    pix(640, 0, rgbx(12'h000), "t3_no_trigger_after_15");
    send(0, 0);
    pix(640, 0, 14'h2000, "t3_trigger_on_16th");
    for (int k = 1; k < 640; k++) begin
      if (k == 639) expect_fd(2, 640);
      send(0, 0);
    end
    idle(4);
    pix(700, 511, rgbx(LC0), "t3_frame_shown");

    // Test 4: decim=3 keeps every 4th valid sample; sample n carries ch0=n.
    do_reset();
    trig_en = 1'b0; decim = 4'd3;
    for (int n = 1; n <= 2560; n++) begin
      if (n == 2560) expect_fd(2, 2556);
      send(n % 1024, 0);
    end
    idle(4);
    pix(640, 509, rgbx(LC0), "t4_col0_n4");
    pix(642, 505, rgbx(LC0), "t4_col2_n12");
    pix(1279, 255, rgbx(LC0), "t4_col639_n2560");
    decim = 4'd0;

    // Test 6: bar mode with full-scale ch1 at columns 3 and 4, then reset blanks the display.
    do_reset();
    bar_mode = 1'b1;
    for (int k = 0; k < 640; k++) begin
      if (k == 639) expect_fd(2, 639);
      send(0, (k == 3 || k == 4) ? 1023 : 0);
    end
    idle(4);
    pix(643, 512, rgbx(LC1), "t6_col3_line");
    pix(643, 513, rgbx(ALTC), "t6_col3_alt_top");
    pix(643, 1023, rgbx(ALTC), "t6_col3_alt_bottom");
    pix(644, 700, rgbx(BARC), "t6_col4_bar");
    pix(643, 511, rgbx(LC0), "t6_col3_lane0_line");
    pix(645, 1023, rgbx(LC1), "t6_col5_line_bottom");
    pix(645, 1022, rgbx(12'h000), "t6_col5_above_line");
    pix(643, 1024, rgbx(12'h000), "t6_below_lanes");
    rst_n = 1'b0;
    pix(643, 513, rgbx(12'h000), "t6_reset_blank");
    rst_n = 1'b1;
    tick();

    end_chk = 1'b1;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
